// File: rtl/darkroom_pkg.sv
// Shared FSM state type, header layout and frame-length helper for the darkroom frame scheduler.
// Defining DARKROOM_FRAME_CRC8_EN adds the CRC state and one trailing CRC-8 byte per frame.
package darkroom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
`ifdef DARKROOM_FRAME_CRC8_EN
    ST_CRC,
`endif
    ST_GAP
  } state_t;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam int         HDR_IDX_OFS  = 0;
  localparam int         HDR_MASK_OFS = 1;
  localparam int         HDR_BYTES    = 2;

  function automatic int frame_len(input int spf);
`ifdef DARKROOM_FRAME_CRC8_EN
    return HDR_BYTES + 4 * spf + 1;
`else
    return HDR_BYTES + 4 * spf;
`endif
  endfunction

endpackage

// File: rtl/darkroom_crc8.sv
// Byte-wise CRC-8 (poly 0x07, init 0x00, unreflected) with a registered accumulator.
// Only instantiated when DARKROOM_FRAME_CRC8_EN is defined.
module darkroom_crc8
  import darkroom_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d, upd;

  always_comb begin
    upd = crc_q ^ data_i;
    for (int b = 0; b < 8; b++) begin
      upd = upd[7] ? ({upd[6:0], 1'b0} ^ CRC8_POLY) : {upd[6:0], 1'b0};
    end
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = upd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/darkroom_frame_scheduler.sv
// Streams byte frames (header + sensor words) for frames holding freshly updated sensors.
// Defining DARKROOM_FRAME_CRC8_EN appends a CRC-8 byte to every frame.
module darkroom_frame_scheduler
  import darkroom_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 32,
  parameter int SENSORS_PER_FRAME = 8,
  parameter int GAP_CYCLES        = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data_i,
  input  logic [NUMBER_OF_SENSORS-1:0]   sensor_update_i,
  input  logic                           trigger_i,
  output logic [7:0]                     byte_o,
  output logic                           byte_valid_o,
  input  logic                           byte_ready_i,
  output logic                           frame_start_o,
  output logic                           frame_end_o,
  output logic                           busy_o,
  output logic [15:0]                    overrun_count_o
);

  localparam int NS        = NUMBER_OF_SENSORS;
  localparam int SPF       = SENSORS_PER_FRAME;
  localparam int NF        = (NS + SPF - 1) / SPF;
  localparam int TOT       = NF * SPF;
  localparam int PADW      = 32 * TOT;
  localparam int FIW       = (NF > 1) ? $clog2(NF) : 1;
  localparam int PAY_BYTES = 4 * SPF;
  localparam int PCW       = $clog2(PAY_BYTES);
  localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t               state_q, state_d;
  logic [NS-1:0]        dirty_q, dirty_d;
  logic [FIW-1:0]       frame_idx_q, frame_idx_d;
  logic                 force_q, force_d;
  logic [32*SPF-1:0]    words_q, words_d;
  logic [SPF-1:0]       mask_q, mask_d;
  logic [PCW-1:0]       pay_cnt_q, pay_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [15:0]          overrun_q, overrun_d;

  logic [PADW-1:0]      pad_words;
  logic [TOT-1:0]       pad_dirty;
  logic [32*SPF-1:0]    sel_words;
  logic [SPF-1:0]       sel_mask;
  logic [NS-1:0]        clr_vec;
  logic                 last_frame, pay_last, frame_done, ovr_hit;

  // Pad the sensor set up to a whole number of frames; phantom slots read as zero, never dirty.
  assign pad_words = PADW'(sensor_data_i);
  assign pad_dirty = TOT'(dirty_q);

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_clr
      assign clr_vec[gi] = (state_q == ST_LOAD) && (frame_idx_q == FIW'(gi / SPF));
    end
  endgenerate

  always_comb begin
    sel_words = '0;
    sel_mask  = '0;
    for (int f = 0; f < NF; f++) begin
      if (frame_idx_q == FIW'(f)) begin
        sel_words = pad_words[32*SPF*f +: 32*SPF];
        sel_mask  = pad_dirty[SPF*f +: SPF];
      end
    end
  end

  assign last_frame = (frame_idx_q == FIW'(NF - 1));
  assign pay_last   = (pay_cnt_q == PCW'(PAY_BYTES - 1));

  // An update landing in its own frame's LOAD cycle keeps dirty set: that word goes next round.
  assign dirty_d   = sensor_update_i | (dirty_q & ~clr_vec);
  assign ovr_hit   = |(sensor_update_i & dirty_q & ~clr_vec);
  assign overrun_d = (ovr_hit && (overrun_q != 16'hFFFF)) ? overrun_q + 16'd1 : overrun_q;

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    force_d     = force_q;
    words_d     = words_q;
    mask_d      = mask_q;
    pay_cnt_d   = pay_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|dirty_q) || trigger_i) begin
          state_d     = ST_LOAD;
          frame_idx_d = '0;
          force_d     = trigger_i;
        end
      end
      ST_LOAD: begin
        words_d   = sel_words;
        mask_d    = sel_mask;
        pay_cnt_d = '0;
        if ((sel_mask == '0) && !force_q) begin
          if (last_frame) begin
            state_d = ST_IDLE;
          end else begin
            frame_idx_d = frame_idx_q + FIW'(1);
          end
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: if (byte_ready_i) state_d = ST_HDR1;
      ST_HDR1: if (byte_ready_i) state_d = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (byte_ready_i) begin
          if (pay_last) begin
`ifdef DARKROOM_FRAME_CRC8_EN
            state_d = ST_CRC;
`else
            frame_done = 1'b1;
`endif
          end else begin
            pay_cnt_d = pay_cnt_q + PCW'(1);
          end
        end
      end
`ifdef DARKROOM_FRAME_CRC8_EN
      ST_CRC: if (byte_ready_i) frame_done = 1'b1;
`endif
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d     = ST_LOAD;
          frame_idx_d = frame_idx_q + FIW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The final frame of a round returns to IDLE without an idle gap.
    if (frame_done) begin
      if (last_frame) begin
        state_d = ST_IDLE;
      end else if (GAP_CYCLES == 0) begin
        state_d     = ST_LOAD;
        frame_idx_d = frame_idx_q + FIW'(1);
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dirty_q     <= '0;
      frame_idx_q <= '0;
      force_q     <= 1'b0;
      words_q     <= '0;
      mask_q      <= '0;
      pay_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      frame_idx_q <= frame_idx_d;
      force_q     <= force_d;
      words_q     <= words_d;
      mask_q      <= mask_d;
      pay_cnt_q   <= pay_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef DARKROOM_FRAME_CRC8_EN
  logic [7:0] crc_val;

  darkroom_crc8 u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (state_q == ST_LOAD),
    .en_i    (byte_valid_o && byte_ready_i && (state_q != ST_CRC)),
    .data_i  (byte_o),
    .crc_o   (crc_val)
  );
`endif

  // Outputs decode only registered state, so they hold steady while the consumer stalls.
  always_comb begin
    byte_o        = '0;
    byte_valid_o  = 1'b0;
    frame_start_o = 1'b0;
    frame_end_o   = 1'b0;
    case (state_q)
      ST_HDR0: begin
        byte_o        = 8'(frame_idx_q);
        byte_valid_o  = 1'b1;
        frame_start_o = 1'b1;
      end
      ST_HDR1: begin
        byte_o       = 8'(mask_q);
        byte_valid_o = 1'b1;
      end
      ST_PAYLOAD: begin
        byte_o       = words_q[{pay_cnt_q, 3'b000} +: 8];
        byte_valid_o = 1'b1;
`ifndef DARKROOM_FRAME_CRC8_EN
        frame_end_o  = pay_last;
`endif
      end
`ifdef DARKROOM_FRAME_CRC8_EN
      ST_CRC: begin
        byte_o       = crc_val;
        byte_valid_o = 1'b1;
        frame_end_o  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign overrun_count_o = overrun_q;

endmodule
